checkpoint_rename_rf_mp: RTL and testbench

CHECKPOINT_RENAME_RF_MP -- requirements
Module: checkpoint_rename_rf_mp

---
 rtl/checkpoint_rename_rf_mp_if.sv | 48 ++++
 rtl/checkpoint_rename_rf_mp.sv | 181 ++++++++++++++++++
 tb/tb_checkpoint_rename_rf_mp.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/checkpoint_rename_rf_mp_if.sv
// Rename / register-file bus: allocation, lookup, data read/write, commit, checkpoint and rollback.
interface checkpoint_rename_rf_mp_if #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int DATA_W    = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int NUM_CHK   = 4
);
  localparam int AW  = $clog2(ARCH_REGS);
  localparam int NW  = $clog2(PHYS_REGS);
  localparam int CW  = $clog2(NUM_CHK);
  localparam int FCW = $clog2(PHYS_REGS + 1);

  logic                           alloc_e;
  logic [AW-1:0]                  alloc_addr;
  logic                           alloc_ready;
  logic [NW-1:0]                  alloc_name;
  logic [NUM_RD-1:0][AW-1:0]      rd_addr;
  logic [NUM_RD-1:0][NW-1:0]      rd_name;
  logic [NUM_RD-1:0][NW-1:0]      rd_data_name;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]              rd_valid;
  logic [NUM_WR-1:0]              wr_e;
  logic [NUM_WR-1:0][NW-1:0]      wr_name;
  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
  logic                           free_e;
  logic [NW-1:0]                  free_name;
  logic                           chk_e;
  logic                           chk_ready;
  logic [CW-1:0]                  chk_id;
  logic                           roll_e;
  logic [CW-1:0]                  roll_id;
  logic                           roll_restore;
  logic [FCW-1:0]                 free_count;

  modport slave (
    input  alloc_e, alloc_addr, rd_addr, rd_data_name, wr_e, wr_name, wr_data,
           free_e, free_name, chk_e, roll_e, roll_id, roll_restore,
    output alloc_ready, alloc_name, rd_name, rd_data, rd_valid, chk_ready, chk_id, free_count
  );

  modport master (
    output alloc_e, alloc_addr, rd_addr, rd_data_name, wr_e, wr_name, wr_data,
           free_e, free_name, chk_e, roll_e, roll_id, roll_restore,
    input  alloc_ready, alloc_name, rd_name, rd_data, rd_valid, chk_ready, chk_id, free_count
  );
endinterface

// File: rtl/checkpoint_rename_rf_mp.sv
// Checkpointed register-rename table with multi-port physical register file.
// Optional RENAME_BYPASS_EN forwards same-cycle writeback data to the read ports.
module checkpoint_rename_rd_lane #(
  parameter int PHYS_REGS = 64,
  parameter int DATA_W    = 32,
  parameter int NUM_WR    = 2,
  parameter int NW        = 6
) (
  input  logic [NW-1:0]                    name_i,
  input  logic [PHYS_REGS-1:0][DATA_W-1:0] phys_i,
  input  logic [PHYS_REGS-1:0]             busy_i,
  input  logic [NUM_WR-1:0]                wr_e_i,
  input  logic [NUM_WR-1:0][NW-1:0]        wr_name_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]    wr_data_i,
  output logic [DATA_W-1:0]                data_o,
  output logic                             valid_o
);
`ifdef RENAME_BYPASS_EN
  // Ascending scan so the highest write port takes the forward.
  always_comb begin
    data_o  = phys_i[name_i];
    valid_o = ~busy_i[name_i];
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_e_i[k] && (wr_name_i[k] == name_i)) begin
        data_o  = wr_data_i[k];
        valid_o = 1'b1;
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_e_i, wr_name_i, wr_data_i};
  always_comb begin
    data_o  = phys_i[name_i];
    valid_o = ~busy_i[name_i];
  end
`endif
endmodule

module checkpoint_rename_rf_mp #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int DATA_W    = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int NUM_CHK   = 4
) (
  input logic clk,
  input logic rst,
  checkpoint_rename_rf_mp_if.slave bus
);
  localparam int NW  = $clog2(PHYS_REGS);
  localparam int CW  = $clog2(NUM_CHK);
  localparam int FCW = $clog2(PHYS_REGS + 1);

  logic [ARCH_REGS-1:0][NW-1:0]              map_q, map_d;
  logic [PHYS_REGS-1:0]                      free_q, free_d, busy_q, busy_d;
  logic [PHYS_REGS-1:0][NW-1:0]              old_q, old_d;
  logic [PHYS_REGS-1:0][DATA_W-1:0]          phys_q, phys_d;
  logic [NUM_CHK-1:0]                        used_q, used_d;
  logic [NUM_CHK-1:0][ARCH_REGS-1:0][NW-1:0] cmap_q, cmap_d;
  logic [NUM_CHK-1:0][PHYS_REGS-1:0]         cfree_q, cfree_d;

  logic [NW-1:0]  alloc_name, rel_name;
  logic [CW-1:0]  chk_id;
  logic [FCW-1:0] free_cnt;
  logic           alloc_ready, alloc_fire, chk_ready, chk_fire;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_valid;
  logic [NUM_RD-1:0][NW-1:0]     rd_name;

  always_comb begin
    alloc_name = '0;
    for (int i = PHYS_REGS-1; i >= 0; i--) if (free_q[i]) alloc_name = NW'(i);
  end

  always_comb begin
    chk_id = '0;
    for (int i = NUM_CHK-1; i >= 0; i--) if (!used_q[i]) chk_id = CW'(i);
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < PHYS_REGS; i++) free_cnt = free_cnt + FCW'(free_q[i]);
  end

  // A restoring rollback rewrites the free list, so allocation stalls that cycle.
  assign alloc_ready = (|free_q) & ~(bus.roll_e & bus.roll_restore);
  assign alloc_fire  = bus.alloc_e & alloc_ready;
  assign chk_ready   = (|(~used_q)) & ~bus.roll_e;
  assign chk_fire    = bus.chk_e & chk_ready;
  assign rel_name    = old_q[bus.free_name];

  always_comb begin
    map_d   = map_q;
    free_d  = free_q;
    old_d   = old_q;
    busy_d  = busy_q;
    phys_d  = phys_q;
    used_d  = used_q;
    cmap_d  = cmap_q;
    cfree_d = cfree_q;
    if (alloc_fire) begin
      map_d[bus.alloc_addr] = alloc_name;
      free_d[alloc_name]    = 1'b0;
      old_d[alloc_name]     = map_q[bus.alloc_addr];
    end
    if (bus.free_e) free_d[rel_name] = 1'b1;
    if (bus.roll_e) begin
      if (bus.roll_restore) begin
        map_d  = cmap_q[bus.roll_id];
        free_d = cfree_q[bus.roll_id];
        if (bus.free_e) free_d[rel_name] = 1'b1;
        used_d = '0;
        used_d[bus.roll_id] = 1'b1;
      end else begin
        used_d[bus.roll_id] = 1'b0;
      end
    end
    // Snapshot the post-update view so same-cycle alloc/free are captured.
    if (chk_fire) begin
      cmap_d[chk_id]  = map_d;
      cfree_d[chk_id] = free_d;
      used_d[chk_id]  = 1'b1;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (bus.wr_e[k]) begin
        phys_d[bus.wr_name[k]] = bus.wr_data[k];
        busy_d[bus.wr_name[k]] = 1'b0;
      end
    end
    if (alloc_fire) busy_d[alloc_name] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= NW'(i);
      for (int i = 0; i < PHYS_REGS; i++) free_q[i] <= (i >= ARCH_REGS);
      busy_q  <= '0;
      old_q   <= '0;
      phys_q  <= '0;
      used_q  <= '0;
      cmap_q  <= '0;
      cfree_q <= '0;
    end else begin
      map_q   <= map_d;
      free_q  <= free_d;
      busy_q  <= busy_d;
      old_q   <= old_d;
      phys_q  <= phys_d;
      used_q  <= used_d;
      cmap_q  <= cmap_d;
      cfree_q <= cfree_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_name[p] = map_q[bus.rd_addr[p]];
    checkpoint_rename_rd_lane #(
      .PHYS_REGS(PHYS_REGS), .DATA_W(DATA_W), .NUM_WR(NUM_WR), .NW(NW)
    ) u_lane (
      .name_i    (bus.rd_data_name[p]),
      .phys_i    (phys_q),
      .busy_i    (busy_q),
      .wr_e_i    (bus.wr_e),
      .wr_name_i (bus.wr_name),
      .wr_data_i (bus.wr_data),
      .data_o    (rd_data[p]),
      .valid_o   (rd_valid[p])
    );
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_name  = alloc_name;
  assign bus.rd_name     = rd_name;
  assign bus.rd_data     = rd_data;
  assign bus.rd_valid    = rd_valid;
  assign bus.chk_ready   = chk_ready;
  assign bus.chk_id      = chk_id;
  assign bus.free_count  = free_cnt;
endmodule

// File: tb/tb_checkpoint_rename_rf_mp.sv
// Directed + randomized bench for checkpoint_rename_rf_mp against an array-based reference model.
module tb_checkpoint_rename_rf_mp;
  localparam int A = 32, P = 64, DW = 32, NR = 2, NWR = 2, NC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  checkpoint_rename_rf_mp_if #(.ARCH_REGS(A), .PHYS_REGS(P), .DATA_W(DW),
    .NUM_RD(NR), .NUM_WR(NWR), .NUM_CHK(NC)) bus ();
  checkpoint_rename_rf_mp #(.ARCH_REGS(A), .PHYS_REGS(P), .DATA_W(DW),
    .NUM_RD(NR), .NUM_WR(NWR), .NUM_CHK(NC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0, n_fail = 0;

  // Reference state: plain arrays describing the rename rules.
  int          m_map [A];
  bit          m_free[P];
  bit          m_busy[P];
  logic [31:0] m_phys[P];
  int          m_old [P];
  bit          m_used[NC];
  int          c_map [NC][A];
  bit          c_free[NC][P];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int low_free();
    for (int i = 0; i < P; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  function automatic int cnt_free();
    int c = 0;
    for (int i = 0; i < P; i++) c += int'(m_free[i]);
    return c;
  endfunction

  function automatic int low_chk();
    for (int i = 0; i < NC; i++) if (!m_used[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < A; i++) m_map[i] = i;
    for (int i = 0; i < P; i++) begin
      m_free[i] = (i >= A); m_busy[i] = 0; m_phys[i] = 0; m_old[i] = 0;
    end
    for (int c = 0; c < NC; c++) begin
      m_used[c] = 0;
      for (int i = 0; i < A; i++) c_map[c][i] = 0;
      for (int i = 0; i < P; i++) c_free[c][i] = 0;
    end
  endtask

  task automatic idle();
    bus.alloc_e = 0; bus.alloc_addr = '0; bus.rd_addr = '0; bus.rd_data_name = '0;
    bus.wr_e = '0; bus.wr_name = '0; bus.wr_data = '0; bus.free_e = 0; bus.free_name = '0;
    bus.chk_e = 0; bus.roll_e = 0; bus.roll_id = '0; bus.roll_restore = 0;
  endtask

  task automatic check_all();
    int af, lc, n;
    logic [31:0] ed;
    bit ev;
    af = low_free();
    lc = low_chk();
    check("alloc_ready", bus.alloc_ready, (af >= 0) && !(bus.roll_e && bus.roll_restore));
    if (af >= 0) check("alloc_name", bus.alloc_name, af);
    check("chk_ready", bus.chk_ready, (lc >= 0) && !bus.roll_e);
    if (lc >= 0) check("chk_id", bus.chk_id, lc);
    check("free_count", bus.free_count, cnt_free());
    for (int p = 0; p < NR; p++) begin
      check("rd_name", bus.rd_name[p], m_map[bus.rd_addr[p]]);
      n  = int'(bus.rd_data_name[p]);
      ed = m_phys[n];
      ev = !m_busy[n];
`ifdef RENAME_BYPASS_EN
      for (int k = 0; k < NWR; k++)
        if (bus.wr_e[k] && int'(bus.wr_name[k]) == n) begin ed = bus.wr_data[k]; ev = 1; end
`endif
      check("rd_data", bus.rd_data[p], ed);
      check("rd_valid", bus.rd_valid[p], ev);
    end
  endtask

  task automatic model_update();
    int nm[A];
    bit nf[P];
    int an, lc, rel, id;
    bit fire, cfire;
    an    = low_free();
    lc    = low_chk();
    fire  = bus.alloc_e && an >= 0 && !(bus.roll_e && bus.roll_restore);
    cfire = bus.chk_e && lc >= 0 && !bus.roll_e;
    rel   = m_old[bus.free_name];
    id    = int'(bus.roll_id);
    nm = m_map;
    nf = m_free;
    if (fire) begin nm[bus.alloc_addr] = an; nf[an] = 0; end
    if (bus.free_e) nf[rel] = 1;
    if (bus.roll_e) begin
      if (bus.roll_restore) begin
        nm = c_map[id];
        nf = c_free[id];
        if (bus.free_e) nf[rel] = 1;
        for (int j = 0; j < NC; j++) m_used[j] = (j == id);
      end else m_used[id] = 0;
    end
    if (cfire) begin c_map[lc] = nm; c_free[lc] = nf; m_used[lc] = 1; end
    if (fire) m_old[an] = m_map[bus.alloc_addr];
    for (int k = 0; k < NWR; k++)
      if (bus.wr_e[k]) begin m_phys[bus.wr_name[k]] = bus.wr_data[k]; m_busy[bus.wr_name[k]] = 0; end
    if (fire) m_busy[an] = 1;
    m_map  = nm;
    m_free = nf;
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_inputs();
    int fn;
    bus.alloc_e    = 1'($urandom_range(0, 1));
    bus.alloc_addr = 5'($urandom_range(0, A-1));
    for (int p = 0; p < NR; p++) begin
      bus.rd_addr[p]      = 5'($urandom_range(0, A-1));
      bus.rd_data_name[p] = 6'($urandom_range(0, P-1));
    end
    for (int k = 0; k < NWR; k++) begin
      bus.wr_e[k]    = ($urandom_range(0, 2) == 0);
      bus.wr_name[k] = 6'($urandom_range(0, P-1));
      bus.wr_data[k] = $urandom;
    end
    fn = $urandom_range(0, P-1);
    bus.free_name = 6'(fn);
    bus.free_e    = ($urandom_range(0, 3) == 0) && !m_free[m_old[fn]];
    bus.chk_e        = ($urandom_range(0, 3) == 0);
    bus.roll_e       = ($urandom_range(0, 7) == 0);
    bus.roll_id      = 2'($urandom_range(0, NC-1));
    bus.roll_restore = 1'($urandom_range(0, 1)) && m_used[bus.roll_id];
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    #12;
    // Reset state, independent constants
    bus.rd_data_name[1] = 6'd40;
    #1;
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_alloc_name", bus.alloc_name, 32);
    check("rst_chk_ready", bus.chk_ready, 1);
    check("rst_chk_id", bus.chk_id, 0);
    check("rst_free_count", bus.free_count, 32);
    check("rst_rd_valid", bus.rd_valid, 2'b11);
    check("rst_rd_data", bus.rd_data, '0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // Rename addr 3
    idle(); bus.alloc_e = 1; bus.alloc_addr = 5'd3;
    #1 check("alloc3_name", bus.alloc_name, 32);
    step();
    idle(); bus.rd_addr[0] = 5'd3; bus.rd_data_name[0] = 6'd32;
    #1;
    check("alloc3_rd_name", bus.rd_name[0], 32);
    check("alloc3_busy", bus.rd_valid[0], 0);
    check("alloc3_free_count", bus.free_count, 31);
    step();

    // Two writes to the same name, highest port wins
    idle(); bus.wr_e = 2'b11; bus.wr_name[0] = 6'd32; bus.wr_name[1] = 6'd32;
    bus.wr_data[0] = 32'hA; bus.wr_data[1] = 32'hB; bus.rd_data_name[0] = 6'd32;
    #1;
`ifdef RENAME_BYPASS_EN
    check("wr_bypass_data", bus.rd_data[0], 32'hB);
    check("wr_bypass_valid", bus.rd_valid[0], 1);
`else
    check("wr_nobypass_valid", bus.rd_valid[0], 0);
`endif
    step();
    idle(); bus.rd_data_name[0] = 6'd32;
    #1;
    check("wr_data", bus.rd_data[0], 32'hB);
    check("wr_valid", bus.rd_valid[0], 1);
    step();

    // Checkpoint with same-cycle rename, then restore
    idle(); bus.chk_e = 1; bus.alloc_e = 1; bus.alloc_addr = 5'd5;
    #1;
    check("chk0_id", bus.chk_id, 0);
    check("chk0_alloc", bus.alloc_name, 33);
    step();
    idle(); bus.alloc_e = 1; bus.alloc_addr = 5'd5;
    #1 check("alloc5b_name", bus.alloc_name, 34);
    step();
    idle(); bus.roll_e = 1; bus.roll_restore = 1; bus.roll_id = 2'd0; bus.alloc_e = 1;
    #1 check("roll_blocks_alloc", bus.alloc_ready, 0);
    step();
    idle(); bus.rd_addr[0] = 5'd5;
    #1;
    check("roll_map5", bus.rd_name[0], 33);
    check("roll_free34", bus.alloc_name, 34);
    check("roll_free_count", bus.free_count, 30);
    check("roll_slot0_kept", bus.chk_id, 1);
    step();

    // Drain the free list
    for (int i = 0; i < P && bus.alloc_ready; i++) begin
      bus.alloc_e = 1; bus.alloc_addr = 5'($urandom_range(0, A-1));
      step();
    end
    idle();
    #1;
    check("empty_ready", bus.alloc_ready, 0);
    check("empty_count", bus.free_count, 0);
    bus.free_e = 1; bus.free_name = 6'd32;
    step();
    idle();
    #1;
    check("refill_ready", bus.alloc_ready, 1);
    check("refill_name", bus.alloc_name, 3);
    step();

    // Fill checkpoints, release one, collide checkpoint with rollback
    for (int i = 0; i < 3; i++) begin idle(); bus.chk_e = 1; step(); end
    idle();
    #1 check("chk_full", bus.chk_ready, 0);
    bus.roll_e = 1; bus.roll_restore = 0; bus.roll_id = 2'd2;
    step();
    idle();
    #1;
    check("rel2_ready", bus.chk_ready, 1);
    check("rel2_id", bus.chk_id, 2);
    bus.chk_e = 1; bus.roll_e = 1; bus.roll_restore = 0; bus.roll_id = 2'd1;
    #1 check("chk_roll_block", bus.chk_ready, 0);
    step();
    idle();
    #1 check("chk_ignored_id", bus.chk_id, 1);
    bus.chk_e = 1;
    step();
    idle();
    #1 check("chk_slot2_free", bus.chk_id, 2);
    step();

    // Randomized traffic against the model
    repeat (400) begin rand_inputs(); step(); end

    // Reset in the middle of activity
    idle(); bus.alloc_e = 1; bus.alloc_addr = 5'd7; bus.chk_e = 1; bus.rd_addr[0] = 5'd7;
    #2;
    rst = 1;
    model_reset();
    #1;
    check("midrst_alloc_name", bus.alloc_name, 32);
    check("midrst_free_count", bus.free_count, 32);
    check("midrst_chk_id", bus.chk_id, 0);
    check("midrst_rd_name", bus.rd_name[0], 7);
    @(posedge clk); #1;
    check("midrst_hold_count", bus.free_count, 32);
    @(negedge clk);
    rst = 0;
    idle();
    @(posedge clk); #1;
    repeat (200) begin rand_inputs(); step(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
